data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory word-address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 req0_in / req1_in  input  1  access request from requester 0 / 1, held until matching ack.
REQ-006 we0_in / we1_in  input  1  1 = write, 0 = read; valid while reqN_in high.
REQ-007 addr0_in / addr1_in  input  ADDR_W  word address; valid while reqN_in high.
REQ-008 wdata0_in / wdata1_in  input  DATA_W  write data; valid while reqN_in high.
REQ-009 ack0_out / ack1_out  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-010 rdata0_out / rdata1_out  output  DATA_W  registered read data for requester 0 / 1.
REQ-011 busy_out  output  1  high whenever the FSM is not in IDLE.
REQ-012 mem_write_en_out  output  1  drives data_memory write_en_in.
REQ-013 mem_addr_out  output  ADDR_W  drives data_memory addr_in.
REQ-014 mem_data_out  output  DATA_W  drives data_memory data_in.
REQ-015 mem_data_in  input  DATA_W  from data_memory data_out; combinational read of mem_addr_out.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS, RESP; IDLE->ACCESS when any reqN_in is high, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-017 In IDLE with exactly one request high, that requester SHALL win.
REQ-018 In IDLE with both requests high, the requester not granted last SHALL win (round-robin); the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-019 On the IDLE->ACCESS edge, the winner id, weN_in, addrN_in and wdataN_in SHALL be latched; later changes on requester inputs SHALL NOT affect the access in flight.
REQ-020 In ACCESS, mem_addr_out and mem_data_out SHALL carry the latched address and data, and mem_write_en_out SHALL equal the latched we, for exactly one cycle.
REQ-021 Outside ACCESS, mem_write_en_out, mem_addr_out and mem_data_out SHALL be 0.
REQ-022 At the ACCESS->RESP edge, for a read, mem_data_in SHALL be captured into the winner's rdataN_out; for a write, the winner's rdataN_out SHALL be loaded with 0.
REQ-023 In RESP, only the winner's ackN_out SHALL be 1, for exactly one cycle, and the last-grant pointer SHALL update to the winner.
REQ-024 rdataN_out SHALL hold its value until that requester's next completed access.
REQ-025 Latency SHALL be fixed: a request sampled at edge N drives memory during cycle N..N+1 and acks during cycle N+1..N+2; the maximum rate is one access per 3 cycles.
REQ-026 A requester SHALL drop reqN_in in the cycle after ackN_out; a request still high in IDLE after RESP SHALL be treated as a new access.
REQ-027 A request deasserted before it is sampled in IDLE SHALL be ignored, with no ack.
REQ-028 Once latched, an access SHALL complete.
REQ-029 busy_out SHALL be high in ACCESS and RESP.

Reset
REQ-030 When rst_n_in is low, all of the following SHALL be forced immediately, without waiting for a clock edge, including mid-access: FSM to IDLE; all outputs to 0; last-grant pointer to 1.
REQ-031 An access aborted by reset SHALL NOT be acked, and SHALL NOT be retried.
REQ-032 After rst_n_in rises, the first access SHALL begin on the first rising edge at which a request is high.

Verification
REQ-033 Write then read, requester 0: write addr 3, data 10, then read addr 3 -> mem_write_en_out high one cycle with mem_addr_out=3 and mem_data_out=10; second ack0_out with rdata0_out=10.
REQ-034 Simultaneous requests: req0 reads addr 4 and req1 reads addr 5, both held -> ack0_out first, then ack1_out 3 cycles later; no cycle has both acks high.
REQ-035 Fairness: both requests held continuously for 12 cycles -> acks alternate 0,1,0,1; busy_out stays high except one IDLE cycle between accesses.
REQ-036 Input change after latch: change addr1_in from 7 to 9 during ACCESS -> mem_addr_out stays 7.
REQ-037 Reset mid-write: assert rst_n_in low during ACCESS of a write to addr 2 -> mem_write_en_out drops to 0 immediately, no ack; after release, a read of addr 2 is acked.
REQ-038 Short request: req1_in high for less than one cycle between edges -> no access and no ack1_out; rdata1_out unchanged.

Source files
------------

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Two-requester round-robin arbiter in front of a single-port
//                data memory. Each access runs IDLE -> ACCESS -> RESP with a
//                fixed latency: one cycle driving the memory, one cycle of ack.
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req0_in,
  input  logic              req1_in,
  input  logic              we0_in,
  input  logic              we1_in,
  input  logic [ADDR_W-1:0] addr0_in,
  input  logic [ADDR_W-1:0] addr1_in,
  input  logic [DATA_W-1:0] wdata0_in,
  input  logic [DATA_W-1:0] wdata1_in,
  output logic              ack0_out,
  output logic              ack1_out,
  output logic [DATA_W-1:0] rdata0_out,
  output logic [DATA_W-1:0] rdata1_out,
  output logic              busy_out,
  output logic              mem_write_en_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                win_q, win_d;     // requester owning the access in flight
  logic                last_q, last_d;   // requester granted most recently
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                busy_q, busy_d;
  logic                grant_id;

  // Pick the winner: a lone request wins, a tie goes to whoever was not last.
  always_comb begin
    grant_id = 1'b0;
    if (req0_in && req1_in) begin
      grant_id = ~last_q;
    end else begin
      grant_id = req1_in;
    end
  end

  // Next-state and next-output logic; memory port regs are zero unless the
  // next state is ACCESS, so the memory is driven for exactly one cycle.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    mem_we_d   = 1'b0;
    mem_addr_d = '0;
    mem_data_d = '0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    busy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_in || req1_in) begin
          state_d    = ACCESS;
          win_d      = grant_id;
          busy_d     = 1'b1;
          mem_we_d   = grant_id ? we1_in    : we0_in;
          mem_addr_d = grant_id ? addr1_in  : addr0_in;
          mem_data_d = grant_id ? wdata1_in : wdata0_in;
        end
      end
      ACCESS: begin
        // Read data is sampled here while the address is still on the port;
        // a write returns zero to its requester.
        state_d = RESP;
        busy_d  = 1'b1;
        last_d  = win_q;
        if (win_q) begin
          ack1_d   = 1'b1;
          rdata1_d = mem_we_q ? '0 : mem_data_in;
        end else begin
          ack0_d   = 1'b1;
          rdata0_d = mem_we_q ? '0 : mem_data_in;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously,
  // abandoning any access in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      last_q     <= 1'b1;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      busy_q     <= busy_d;
    end
  end

  assign ack0_out         = ack0_q;
  assign ack1_out         = ack1_q;
  assign rdata0_out       = rdata0_q;
  assign rdata1_out       = rdata1_q;
  assign busy_out         = busy_q;
  assign mem_write_en_out = mem_we_q;
  assign mem_addr_out     = mem_addr_q;
  assign mem_data_out     = mem_data_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Self-checking bench for data_mem_arbiter. A transaction-level
//                model schedules the expected memory cycle, ack and read data
//                of every granted access; outputs are compared each negedge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int MAXC   = 4096;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              req0_in, req1_in, we0_in, we1_in;
  logic [ADDR_W-1:0] addr0_in, addr1_in;
  logic [DATA_W-1:0] wdata0_in, wdata1_in;
  logic              ack0_out, ack1_out, busy_out, mem_write_en_out;
  logic [DATA_W-1:0] rdata0_out, rdata1_out, mem_data_out, mem_data_in;
  logic [ADDR_W-1:0] mem_addr_out;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req0_in(req0_in), .req1_in(req1_in),
    .we0_in(we0_in), .we1_in(we1_in),
    .addr0_in(addr0_in), .addr1_in(addr1_in),
    .wdata0_in(wdata0_in), .wdata1_in(wdata1_in),
    .ack0_out(ack0_out), .ack1_out(ack1_out),
    .rdata0_out(rdata0_out), .rdata1_out(rdata1_out),
    .busy_out(busy_out), .mem_write_en_out(mem_write_en_out),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return (DATA_W'(a) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // Attached data memory: combinational read, write on rising edge.
  logic [DATA_W-1:0] mem [0:255];
  assign mem_data_in = mem[mem_addr_out];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk_in);
      if (mem_write_en_out) mem[mem_addr_out] = mem_data_out;
    end
  end

  // ---------------- reference model ----------------
  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc;
  int                next_free;
  bit                m_last;
  logic [DATA_W-1:0] m_rd0, m_rd1;
  logic [DATA_W-1:0] ref_mem [0:255];
  bit                e_we [MAXC];
  logic [ADDR_W-1:0] e_addr [MAXC];
  logic [DATA_W-1:0] e_data [MAXC];
  bit                e_ack0 [MAXC], e_ack1 [MAXC], e_busy [MAXC];
  bit                u_rd0 [MAXC], u_rd1 [MAXC], u_mem [MAXC];
  logic [DATA_W-1:0] u_rd0v [MAXC], u_rd1v [MAXC], u_memd [MAXC];
  logic [ADDR_W-1:0] u_mema [MAXC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_sched(input int from);
    for (int i = from; i < MAXC; i++) begin
      e_we[i] = 0; e_addr[i] = '0; e_data[i] = '0;
      e_ack0[i] = 0; e_ack1[i] = 0; e_busy[i] = 0;
      u_rd0[i] = 0; u_rd1[i] = 0; u_mem[i] = 0;
      u_rd0v[i] = '0; u_rd1v[i] = '0; u_memd[i] = '0; u_mema[i] = '0;
    end
  endtask

  task automatic model_reset();
    clear_sched(cyc + 1);
    m_rd0 = '0; m_rd1 = '0; m_last = 1'b1; next_free = 0;
  endtask

  // Decide what the coming rising edge starts, given the inputs now applied.
  // An access started at this point shows its memory cycle at the next
  // sample, its ack one sample later, and frees the arbiter a sample after.
  task automatic predict();
    bit                w;
    bit                we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    if (rst_n_in && cyc >= next_free && (req0_in || req1_in) && cyc + 3 < MAXC) begin
      w  = (req0_in && req1_in) ? !m_last : req1_in;
      we = w ? we1_in : we0_in;
      a  = w ? addr1_in : addr0_in;
      d  = w ? wdata1_in : wdata0_in;
      e_we[cyc+1] = we; e_addr[cyc+1] = a; e_data[cyc+1] = d;
      e_busy[cyc+1] = 1; e_busy[cyc+2] = 1;
      if (w) begin
        e_ack1[cyc+2] = 1; u_rd1[cyc+2] = 1; u_rd1v[cyc+2] = we ? '0 : ref_mem[a];
      end else begin
        e_ack0[cyc+2] = 1; u_rd0[cyc+2] = 1; u_rd0v[cyc+2] = we ? '0 : ref_mem[a];
      end
      if (we) begin
        u_mem[cyc+2] = 1; u_mema[cyc+2] = a; u_memd[cyc+2] = d;
      end
      next_free = cyc + 3;
      m_last    = w;
    end
  endtask

  task automatic compare_all();
    if (u_mem[cyc]) ref_mem[u_mema[cyc]] = u_memd[cyc];
    if (u_rd0[cyc]) m_rd0 = u_rd0v[cyc];
    if (u_rd1[cyc]) m_rd1 = u_rd1v[cyc];
    chk("mem_we",   mem_write_en_out, e_we[cyc]);
    chk("mem_addr", mem_addr_out,     e_addr[cyc]);
    chk("mem_data", mem_data_out,     e_data[cyc]);
    chk("ack0",     ack0_out,         e_ack0[cyc]);
    chk("ack1",     ack1_out,         e_ack1[cyc]);
    chk("ack_excl", ack0_out & ack1_out, 1'b0);
    chk("busy",     busy_out,         e_busy[cyc]);
    chk("rdata0",   rdata0_out,       m_rd0);
    chk("rdata1",   rdata1_out,       m_rd1);
  endtask

  task automatic tick();
    predict();
    @(negedge clk_in);
    cyc++;
    compare_all();
  endtask

  // Run one access for a requester to its ack, then let the arbiter go idle.
  task automatic do_access(input bit id, input bit we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    bit seen;
    seen = 0;
    if (id) begin req1_in = 1; we1_in = we; addr1_in = a; wdata1_in = d; end
    else    begin req0_in = 1; we0_in = we; addr0_in = a; wdata0_in = d; end
    for (int t = 0; t < 12 && !seen; t++) begin
      tick();
      if (id ? ack1_out : ack0_out) seen = 1;
    end
    if (!seen) chk("ack_timeout", 0, 1);
    if (id) req1_in = 0; else req0_in = 0;
    tick();
  endtask

  initial begin
    int t0, t1, prev;
    cyc = 0; next_free = 0; m_last = 1'b1; m_rd0 = '0; m_rd1 = '0;
    clear_sched(0);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    rst_n_in = 0;
    req0_in = 0; req1_in = 0; we0_in = 0; we1_in = 0;
    addr0_in = '0; addr1_in = '0; wdata0_in = '0; wdata1_in = '0;

    // reset state
    @(negedge clk_in);
    compare_all();
    tick();
    rst_n_in = 1;

    // write then read back on requester 0
    do_access(0, 1, 8'd3, 32'd10);
    do_access(0, 0, 8'd3, 32'd0);
    chk("wr_rd_data", rdata0_out, 32'd10);

    // simultaneous reads: after requester 1 was served, the tie goes to 0
    do_access(1, 0, 8'd5, 32'd0);
    req0_in = 1; we0_in = 0; addr0_in = 8'd4;
    req1_in = 1; we1_in = 0; addr1_in = 8'd5;
    t0 = -1; t1 = -1;
    for (int t = 0; t < 12 && (req0_in || req1_in); t++) begin
      tick();
      if (ack0_out) begin t0 = cyc; req0_in = 0; end
      if (ack1_out) begin t1 = cyc; req1_in = 0; end
    end
    chk("tie_ack0_seen", t0 >= 0, 1'b1);
    chk("tie_ack_gap", 64'(t1 - t0), 64'd3);
    req0_in = 0; req1_in = 0;
    repeat (2) tick();

    // fairness: both held continuously, acks must alternate
    req0_in = 1; we0_in = 0; addr0_in = 8'd1;
    req1_in = 1; we1_in = 0; addr1_in = 8'd2;
    prev = -1;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (ack0_out || ack1_out) begin
        if (prev >= 0) chk("rr_alternate", ack1_out, prev == 0);
        prev = ack1_out ? 1 : 0;
      end
    end
    req0_in = 0; req1_in = 0;
    repeat (4) tick();

    // requester input changes after latch do not reach the memory
    req1_in = 1; we1_in = 0; addr1_in = 8'd7;
    tick();
    chk("latch_addr", mem_addr_out, 8'd7);
    addr1_in = 8'd9;
    #1;
    chk("latch_addr_hold", mem_addr_out, 8'd7);
    for (int t = 0; t < 4 && req1_in; t++) begin
      tick();
      if (ack1_out) req1_in = 0;
    end
    req1_in = 0;
    tick();

    // reset in the middle of a write to address 2
    req0_in = 1; we0_in = 1; addr0_in = 8'd2; wdata0_in = 32'hDEAD_BEEF;
    tick();
    chk("pre_rst_we", mem_write_en_out, 1'b1);
    #2 rst_n_in = 0;
    #1;
    chk("rst_we_now",   mem_write_en_out, 1'b0);
    chk("rst_addr_now", mem_addr_out, 8'd0);
    chk("rst_busy_now", busy_out, 1'b0);
    req0_in = 0;
    model_reset();
    repeat (2) tick();
    rst_n_in = 1;
    do_access(0, 0, 8'd2, 32'd0);
    chk("rd_after_abort", rdata0_out, init_val(2));

    // short request pulse between edges is never seen
    predict();
    #1 req1_in = 1;
    #2 req1_in = 0;
    @(negedge clk_in);
    cyc++;
    compare_all();
    repeat (3) tick();
    chk("short_req_rd1", rdata1_out, m_rd1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      tick();
      if (req0_in && ack0_out) begin
        if ($urandom_range(1) == 1) begin
          we0_in = 1'($urandom_range(1)); addr0_in = ADDR_W'($urandom_range(15)); wdata0_in = $urandom;
        end else req0_in = 0;
      end else if (!req0_in && $urandom_range(2) == 0) begin
        req0_in = 1; we0_in = 1'($urandom_range(1));
        addr0_in = ADDR_W'($urandom_range(15)); wdata0_in = $urandom;
      end
      if (req1_in && ack1_out) begin
        if ($urandom_range(1) == 1) begin
          we1_in = 1'($urandom_range(1)); addr1_in = ADDR_W'($urandom_range(15)); wdata1_in = $urandom;
        end else req1_in = 0;
      end else if (!req1_in && $urandom_range(2) == 0) begin
        req1_in = 1; we1_in = 1'($urandom_range(1));
        addr1_in = ADDR_W'($urandom_range(15)); wdata1_in = $urandom;
      end
    end
    req0_in = 0; req1_in = 0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
